// File: rtl/spi_seq_defs.sv
// Shared definitions for the SPI command sequencer: opcodes, FSM states and
// instruction field positions.
package spi_seq_defs;

  localparam logic [1:0] OP_CMD   = 2'b00;
  localparam logic [1:0] OP_DATA  = 2'b01;
  localparam logic [1:0] OP_DELAY = 2'b10;
  localparam logic [1:0] OP_END   = 2'b11;

  localparam int OPCODE_MSB  = 9;
  localparam int OPCODE_LSB  = 8;
  localparam int PAYLOAD_MSB = 7;
  localparam int PAYLOAD_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_SEND   = 3'd3,
    ST_DELAY  = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_t;

endpackage

// File: rtl/seq_delay_timer.sv
// Programmable delay timer: a prescaler that wraps every DELAY_UNIT cycles
// and an 8-bit unit down-counter. 'expired' is high during the final cycle
// of the programmed delay so the caller can leave on that same edge.
module seq_delay_timer #(
  parameter int DELAY_UNIT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] units,
  output logic       expired
);

  localparam int PRE_W = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
  localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(DELAY_UNIT - 1);

  logic [PRE_W-1:0] r_prescale;
  logic [7:0]       r_units;

  // Count down prescaler; each wrap consumes one unit until units reach zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prescale <= '0;
      r_units    <= '0;
    end else if (load) begin
      r_prescale <= PRE_RELOAD;
      r_units    <= units;
    end else if (r_units != 8'd0) begin
      if (r_prescale == '0) begin
        r_prescale <= PRE_RELOAD;
        r_units    <= r_units - 8'd1;
      end else begin
        r_prescale <= r_prescale - PRE_W'(1);
      end
    end
  end

  assign expired = (r_units == 8'd1) && (r_prescale == '0);

endmodule

// File: rtl/spi_cmd_sequencer.sv
// SPI command sequencer: walks the instruction memory from address 0, emits
// command/data bytes over a valid/ready handshake, runs programmed delays and
// stops at END or when the last address has been executed.
module spi_cmd_sequencer
  import spi_seq_defs::*;
#(
  parameter int ADDR_W     = 4,
  parameter int INSTR_W    = 10,
  parameter int DELAY_UNIT = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] memAddr,
  input  logic [INSTR_W-1:0] memData,
  output logic              txValid,
  input  logic              txReady,
  output logic [7:0]        txData,
  output logic              txDc,
  output logic              csN,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  seq_state_t        r_state, w_stateNext;
  logic [ADDR_W-1:0] r_memAddr, w_memAddrNext;
  logic              r_txValid, w_txValidNext;
  logic [7:0]        r_txData, w_txDataNext;
  logic              r_txDc, w_txDcNext;
  logic              r_csN, w_csNNext;
  logic              r_done, w_doneNext;
  logic              w_load;
  logic              w_advance;
  logic              w_expired;
  logic [1:0]        w_opcode;
  logic [7:0]        w_payload;

  assign w_opcode  = memData[OPCODE_MSB:OPCODE_LSB];
  assign w_payload = memData[PAYLOAD_MSB:PAYLOAD_LSB];

  seq_delay_timer #(
    .DELAY_UNIT(DELAY_UNIT)
  ) u_delay_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_load),
    .units  (w_payload),
    .expired(w_expired)
  );

  // Next-state and next-output decode; 'advance' moves to the next address or ends on exhaustion.
  always_comb begin
    w_stateNext   = r_state;
    w_memAddrNext = r_memAddr;
    w_txValidNext = r_txValid;
    w_txDataNext  = r_txData;
    w_txDcNext    = r_txDc;
    w_csNNext     = r_csN;
    w_doneNext    = r_done;
    w_load        = 1'b0;
    w_advance     = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_memAddrNext = '0;
          w_doneNext    = 1'b0;
          w_csNNext     = 1'b0;
          w_stateNext   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_stateNext = ST_DECODE;
      end
      ST_DECODE: begin
        case (w_opcode)
          OP_CMD, OP_DATA: begin
            w_txDataNext  = w_payload;
            w_txDcNext    = (w_opcode == OP_DATA);
            w_txValidNext = 1'b1;
            w_stateNext   = ST_SEND;
          end
          OP_DELAY: begin
            if (w_payload != 8'd0) begin
              w_load      = 1'b1;
              w_stateNext = ST_DELAY;
            end else begin
              w_advance = 1'b1;
            end
          end
          default: begin
            w_csNNext   = 1'b1;
            w_doneNext  = 1'b1;
            w_stateNext = ST_DONE;
          end
        endcase
      end
      ST_SEND: begin
        if (r_txValid && txReady) begin
          w_txValidNext = 1'b0;
          w_advance     = 1'b1;
        end
      end
      ST_DELAY: begin
        if (w_expired) begin
          w_advance = 1'b1;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase

    if (w_advance) begin
      if (r_memAddr != LAST_ADDR) begin
        w_memAddrNext = r_memAddr + ADDR_W'(1);
        w_stateNext   = ST_FETCH;
      end else begin
        w_csNNext   = 1'b1;
        w_doneNext  = 1'b1;
        w_stateNext = ST_DONE;
      end
    end
  end

  // State and registered outputs, synchronously reset to the idle/deselected condition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_memAddr <= '0;
      r_txValid <= 1'b0;
      r_txData  <= 8'd0;
      r_txDc    <= 1'b0;
      r_csN     <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_memAddr <= w_memAddrNext;
      r_txValid <= w_txValidNext;
      r_txData  <= w_txDataNext;
      r_txDc    <= w_txDcNext;
      r_csN     <= w_csNNext;
      r_done    <= w_doneNext;
    end
  end

  assign memAddr = r_memAddr;
  assign txValid = r_txValid;
  assign txData  = r_txData;
  assign txDc    = r_txDc;
  assign csN     = r_csN;
  assign done    = r_done;
  assign busy    = (r_state != ST_IDLE) && (r_state != ST_DONE);

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Self-checking bench for spi_cmd_sequencer. A program-level model predicts
// every byte, its handshake cycle and the cycle done rises, given the
// per-transfer stall plan the bench will apply on txReady.
module tb_spi_cmd_sequencer;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int DU     = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              txReady = 1'b0;
  logic [ADDR_W-1:0] memAddr;
  logic [9:0]        memData;
  logic              txValid;
  logic [7:0]        txData;
  logic              txDc;
  logic              csN;
  logic              busy;
  logic              done;

  logic [9:0] mem [DEPTH];

  typedef struct {
    logic [7:0] d;
    logic       dc;
    int         cyc;
    int         stall;
  } xfer_t;

  xfer_t expQ[$];
  int    stallPlan [DEPTH];
  int    expDone;
  int    expAddr;
  int    errors = 0;
  int    checks = 0;

  spi_cmd_sequencer #(
    .ADDR_W    (ADDR_W),
    .INSTR_W   (10),
    .DELAY_UNIT(DU)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .memAddr(memAddr),
    .memData(memData),
    .txValid(txValid),
    .txReady(txReady),
    .txData (txData),
    .txDc   (txDc),
    .csN    (csN),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) memData <= mem[memAddr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle 1 is the first cycle after the start edge. Each instruction spends
  // FETCH+DECODE, then its own cost; a handshake at cycle h leads to FETCH at h+1.
  function automatic void buildModel();
    int         t;
    bit         fin;
    logic [1:0] op;
    logic [7:0] pl;
    xfer_t      x;
    expQ.delete();
    t   = 1;
    fin = 1'b0;
    for (int pc = 0; pc < DEPTH && !fin; pc++) begin
      op = mem[pc][9:8];
      pl = mem[pc][7:0];
      case (op)
        2'b00, 2'b01: begin
          x.d     = pl;
          x.dc    = op[0];
          x.stall = stallPlan[expQ.size()];
          x.cyc   = t + 2 + x.stall;
          expQ.push_back(x);
          t = x.cyc + 1;
        end
        2'b10: t = t + 2 + int'(pl) * DU;
        default: begin
          expDone = t + 2;
          expAddr = pc;
          fin     = 1'b1;
        end
      endcase
      if (!fin && pc == DEPTH - 1) begin
        expDone = t;
        expAddr = pc;
        fin     = 1'b1;
      end
    end
  endfunction

  task automatic clearStalls();
    for (int i = 0; i < DEPTH; i++) stallPlan[i] = 0;
  endtask

  task automatic loadProgA();
    for (int i = 0; i < DEPTH; i++) mem[i] = 10'h300;
    mem[0] = {2'b00, 8'hAE};
    mem[1] = {2'b01, 8'h55};
    mem[2] = {2'b11, 8'h00};
  endtask

  task automatic runProgram(input string name, input bit noise);
    int k       = 0;
    int waitCnt = 0;
    int csBad   = 0;
    bit seenDone = 1'b0;
    buildModel();
    @(posedge clk); #1;
    start   = 1'b1;
    txReady = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, ":doneCleared"}, {31'd0, done}, 32'd0);
    check({name, ":csNLow"}, {31'd0, csN}, 32'd0);
    check({name, ":busyHigh"}, {31'd0, busy}, 32'd1);
    for (int c = 1; c <= 2000 && !seenDone; c++) begin
      start = 1'b0;
      if (done) begin
        seenDone = 1'b1;
        check({name, ":doneCycle"}, c, expDone);
        check({name, ":csNEnd"}, {31'd0, csN}, 32'd1);
        check({name, ":busyEnd"}, {31'd0, busy}, 32'd0);
        check({name, ":memAddrEnd"}, {28'd0, memAddr}, expAddr);
        check({name, ":xferCount"}, k, expQ.size());
      end else begin
        if (csN !== 1'b0 || busy !== 1'b1) csBad++;
        if (txValid) begin
          if (k < expQ.size()) begin
            check({name, ":txData"}, {24'd0, txData}, {24'd0, expQ[k].d});
            check({name, ":txDc"}, {31'd0, txDc}, {31'd0, expQ[k].dc});
            txReady = (waitCnt >= expQ[k].stall);
            if (txReady) begin
              check({name, ":xferCycle"}, c, expQ[k].cyc);
              k++;
              waitCnt = 0;
            end else begin
              waitCnt++;
            end
          end else begin
            check({name, ":extraXfer"}, 32'd1, 32'd0);
            txReady = 1'b1;
          end
        end else begin
          txReady = 1'($urandom_range(0, 1));
        end
        if (noise && $urandom_range(0, 7) == 0) start = 1'b1;
        @(posedge clk); #1;
      end
    end
    start   = 1'b0;
    txReady = 1'b0;
    if (!seenDone) check({name, ":timeout"}, 32'd0, 32'd1);
    check({name, ":csNBusyWhileRunning"}, csBad, 32'd0);
  endtask

  initial begin
    bit sawValid;
    clearStalls();
    loadProgA();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset:memAddr", {28'd0, memAddr}, 32'd0);
    check("reset:txValid", {31'd0, txValid}, 32'd0);
    check("reset:txData", {24'd0, txData}, 32'd0);
    check("reset:txDc", {31'd0, txDc}, 32'd0);
    check("reset:csN", {31'd0, csN}, 32'd1);
    check("reset:done", {31'd0, done}, 32'd0);
    check("reset:busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // Basic CMD/DATA/END, no backpressure
    runProgram("progA", 1'b0);

    // Same program with a 5-cycle stall on the first byte; rerun from DONE
    stallPlan[0] = 5;
    runProgram("progAStall", 1'b0);
    clearStalls();

    // DELAY 3 then CMD 0x01
    for (int i = 0; i < DEPTH; i++) mem[i] = 10'h300;
    mem[0] = {2'b10, 8'd3};
    mem[1] = {2'b00, 8'h01};
    runProgram("delay3", 1'b0);

    // DELAY 0 behaves as a no-op
    mem[0] = {2'b10, 8'd0};
    mem[1] = {2'b00, 8'h10};
    runProgram("delay0", 1'b0);

    // Address exhaustion: 16 commands, no END
    for (int i = 0; i < DEPTH; i++) mem[i] = {2'b00, 8'(i)};
    runProgram("exhaust", 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("exhaust:memAddrHold", {28'd0, memAddr}, 32'd15);
      check("exhaust:doneHold", {31'd0, done}, 32'd1);
    end

    // Random programs with random stalls and stray start pulses while busy
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: mem[i] = {2'b00, 8'($urandom_range(0, 255))};
          4, 5, 6:    mem[i] = {2'b01, 8'($urandom_range(0, 255))};
          7, 8:       mem[i] = {2'b10, 8'($urandom_range(0, 4))};
          default:    mem[i] = {2'b11, 8'($urandom_range(0, 255))};
        endcase
        stallPlan[i] = $urandom_range(0, 3);
      end
      runProgram("random", 1'b1);
    end
    clearStalls();

    // Reset while SEND is stalled
    loadProgA();
    @(posedge clk); #1;
    start   = 1'b1;
    txReady = 1'b0;
    @(posedge clk); #1;
    start    = 1'b0;
    sawValid = 1'b0;
    for (int c = 0; c < 10 && !sawValid; c++) begin
      if (txValid) sawValid = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("rstSend:sawValid", {31'd0, sawValid}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rstSend:txValid", {31'd0, txValid}, 32'd0);
    check("rstSend:csN", {31'd0, csN}, 32'd1);
    check("rstSend:memAddr", {28'd0, memAddr}, 32'd0);
    check("rstSend:busy", {31'd0, busy}, 32'd0);
    check("rstSend:done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    // Program still runs cleanly after the mid-transfer reset
    runProgram("afterReset", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
